// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: ALU op codes, forwarding selects,
// writeback-source selects and conditional-branch funct3 codes.
// No ports (package).
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  // 2'b11 is reserved and behaves like FWD_REG.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_f3_e;

endpackage

// File: rtl/execute_cycle_alu.sv
// alu: combinational XLEN-wide integer ALU for the execute stage.
// Ports:
//   SrcA, SrcB  operands
//   ALUControl  operation (riscv_pkg::alu_op_e encoding)
//   Result      wrap-around result; slt yields 0/1; shifts use SrcB[4:0]
//   Zero        Result == 0
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  logic slt_bit;

  assign slt_bit = ($signed(SrcA) < $signed(SrcB));

  always_comb begin
    Result = '0;
    case (alu_op_e'(ALUControl))
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_XOR: Result = SrcA ^ SrcB;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, slt_bit};
      ALU_SLL: Result = SrcA << SrcB[4:0];
      ALU_SRL: Result = SrcA >> SrcB[4:0];
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage of the 5-stage RV32I pipeline.
// Applies operand forwarding, runs the ALU, resolves branches/jumps back to
// fetch and registers results into the EX/MEM pipeline register.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   *E control/data inputs   ID/EX register outputs
//   ResultW                  writeback result for forwarding
//   ForwardAE/ForwardBE      forwarding selects from the hazard unit
//   PCSrcE, PCTargetE        combinational redirect to fetch
//   *M outputs               EX/MEM register (forced to 0 while rst=0)
// Optional: define EXEC_FULL_BRANCH_EN to add Funct3E and decode the full
// set of conditional branches; otherwise branches are beq only.
module execute_cycle
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteE,
  input  logic [1:0]           ResultSrcE,
  input  logic                 MemWriteE,
  input  logic                 JumpE,
  input  logic                 BranchE,
  input  logic [2:0]           ALUControlE,
  input  logic                 ALUSrcE,
  input  logic [XLEN-1:0]      RD1E,
  input  logic [XLEN-1:0]      RD2E,
  input  logic [XLEN-1:0]      PCE,
  input  logic [XLEN-1:0]      ImmExtE,
  input  logic [XLEN-1:0]      PCPlus4E,
  input  logic [REGADDR_W-1:0] RDE,
  input  logic [XLEN-1:0]      ResultW,
  input  logic [1:0]           ForwardAE,
  input  logic [1:0]           ForwardBE,
`ifdef EXEC_FULL_BRANCH_EN
  input  logic [2:0]           Funct3E,
`endif
  output logic                 PCSrcE,
  output logic [XLEN-1:0]      PCTargetE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic [1:0]           ResultSrcM,
  output logic [REGADDR_W-1:0] RDM,
  output logic [XLEN-1:0]      ALUResultM,
  output logic [XLEN-1:0]      WriteDataM,
  output logic [XLEN-1:0]      PCPlus4M
);

  logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE, ALUResultE;
  logic            ZeroE, branch_taken;

  // EX/MEM register
  logic                 regwrite_q, regwrite_d;
  logic                 memwrite_q, memwrite_d;
  logic [1:0]           resultsrc_q, resultsrc_d;
  logic [REGADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]      alu_q, alu_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [XLEN-1:0]      pc4_q, pc4_d;

  // Forwarding muxes; the MEM path reads the registered (pre-edge) result.
  always_comb begin
    SrcAE = RD1E;
    case (ForwardAE)
      FWD_WB:  SrcAE = ResultW;
      FWD_MEM: SrcAE = alu_q;
      default: SrcAE = RD1E;
    endcase
  end

  always_comb begin
    WriteDataE = RD2E;
    case (ForwardBE)
      FWD_WB:  WriteDataE = ResultW;
      FWD_MEM: WriteDataE = alu_q;
      default: WriteDataE = RD2E;
    endcase
  end

  assign SrcBE = ALUSrcE ? ImmExtE : WriteDataE;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (SrcAE),
    .SrcB       (SrcBE),
    .ALUControl (ALUControlE),
    .Result     (ALUResultE),
    .Zero       (ZeroE)
  );

`ifdef EXEC_FULL_BRANCH_EN
  // Compares operate on the forwarded register operands, not the ALU result.
  always_comb begin
    branch_taken = 1'b0;
    case (Funct3E)
      BR_EQ:   branch_taken = (SrcAE == WriteDataE);
      BR_NE:   branch_taken = (SrcAE != WriteDataE);
      BR_LT:   branch_taken = ($signed(SrcAE) <  $signed(WriteDataE));
      BR_GE:   branch_taken = ($signed(SrcAE) >= $signed(WriteDataE));
      BR_LTU:  branch_taken = (SrcAE <  WriteDataE);
      BR_GEU:  branch_taken = (SrcAE >= WriteDataE);
      default: branch_taken = 1'b0;
    endcase
  end
`else
  assign branch_taken = ZeroE;
`endif

  assign PCSrcE    = rst & (JumpE | (BranchE & branch_taken));
  assign PCTargetE = PCE + ImmExtE;

  always_comb begin
    regwrite_d  = RegWriteE;
    memwrite_d  = MemWriteE;
    resultsrc_d = ResultSrcE;
    rd_d        = RDE;
    alu_d       = ALUResultE;
    wdata_d     = WriteDataE;
    pc4_d       = PCPlus4E;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      resultsrc_q <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      pc4_q       <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      pc4_q       <= pc4_d;
    end
  end

  assign RegWriteM  = rst & regwrite_q;
  assign MemWriteM  = rst & memwrite_q;
  assign ResultSrcM = rst ? resultsrc_q : '0;
  assign RDM        = rst ? rd_q        : '0;
  assign ALUResultM = rst ? alu_q       : '0;
  assign WriteDataM = rst ? wdata_q     : '0;
  assign PCPlus4M   = rst ? pc4_q       : '0;

endmodule

// File: tb/tb_execute_cycle.sv
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
  logic [4:0]  RDE;
  logic [2:0]  Funct3E;
  logic        PCSrcE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RDM;

  execute_cycle #(.XLEN(32), .REGADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteE   (RegWriteE),
    .ResultSrcE  (ResultSrcE),
    .MemWriteE   (MemWriteE),
    .JumpE       (JumpE),
    .BranchE     (BranchE),
    .ALUControlE (ALUControlE),
    .ALUSrcE     (ALUSrcE),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .PCE         (PCE),
    .ImmExtE     (ImmExtE),
    .PCPlus4E    (PCPlus4E),
    .RDE         (RDE),
    .ResultW     (ResultW),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
`ifdef EXEC_FULL_BRANCH_EN
    .Funct3E     (Funct3E),
`endif
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RDM         (RDM),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .PCPlus4M    (PCPlus4M)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model of the EX/MEM contents
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;
  logic        m_rw, m_mw;
  logic [1:0]  m_rs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0; m_rw = 0; m_mw = 0; m_rs = 0;
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return r;
  endfunction

  task automatic model_eval(output logic [31:0] alu, output logic [31:0] wd,
                            output logic [31:0] tgt, output logic pcs);
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic        taken;
    a  = pick(ForwardAE, RD1E, ResultW, m_alu);
    wd = pick(ForwardBE, RD2E, ResultW, m_alu);
    b  = ALUSrcE ? ImmExtE : wd;
    sh = b[4:0];
    case (ALUControlE)
      3'd0: alu = a + b;
      3'd1: alu = a - b;
      3'd2: alu = a & b;
      3'd3: alu = a | b;
      3'd4: alu = a ^ b;
      3'd5: alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: alu = a << sh;
      default: alu = a >> sh;
    endcase
`ifdef EXEC_FULL_BRANCH_EN
    case (Funct3E)
      3'd0: taken = (a == wd);
      3'd1: taken = (a != wd);
      3'd4: taken = ($signed(a) < $signed(wd));
      3'd5: taken = ($signed(a) >= $signed(wd));
      3'd6: taken = (a < wd);
      3'd7: taken = (a >= wd);
      default: taken = 1'b0;
    endcase
`else
    taken = (alu == 0);
`endif
    pcs = rst && (JumpE || (BranchE && taken));
    tgt = PCE + ImmExtE;
  endtask

  task automatic chk_m(input string tag);
    chk({tag, ".RegWriteM"},  {31'd0, RegWriteM}, {31'd0, m_rw});
    chk({tag, ".MemWriteM"},  {31'd0, MemWriteM}, {31'd0, m_mw});
    chk({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, m_rs});
    chk({tag, ".RDM"},        {27'd0, RDM}, {27'd0, m_rd});
    chk({tag, ".ALUResultM"}, ALUResultM, m_alu);
    chk({tag, ".WriteDataM"}, WriteDataM, m_wd);
    chk({tag, ".PCPlus4M"},   PCPlus4M, m_pc4);
  endtask

  // Called just after a rising edge with the E inputs already driven.
  task automatic step(input string tag);
    logic [31:0] e_alu, e_wd, e_tgt;
    logic        e_pcs;
    model_eval(e_alu, e_wd, e_tgt, e_pcs);
    #2;
    chk({tag, ".PCSrcE"}, {31'd0, PCSrcE}, {31'd0, e_pcs});
    chk({tag, ".PCTargetE"}, PCTargetE, e_tgt);
    @(posedge clk); #1;
    m_alu = e_alu; m_wd = e_wd; m_pc4 = PCPlus4E; m_rd = RDE;
    m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE;
    chk_m(tag);
  endtask

  task automatic zero_ctrl();
    RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
    ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0; ALUControlE = 0; Funct3E = 0;
  endtask

  task automatic randomize_inputs();
    RegWriteE   = 1'($urandom);
    MemWriteE   = 1'($urandom);
    JumpE       = ($urandom_range(0, 7) == 0);
    BranchE     = 1'($urandom);
    ALUSrcE     = 1'($urandom);
    ResultSrcE  = 2'($urandom_range(0, 2));
    ForwardAE   = 2'($urandom);
    ForwardBE   = 2'($urandom);
    ALUControlE = 3'($urandom);
    Funct3E     = 3'($urandom);
    RD1E        = $urandom;
    RD2E        = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
    PCE         = $urandom;
    ImmExtE     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    PCPlus4E    = PCE + 4;
    RDE         = 5'($urandom);
    ResultW     = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      ForwardAE = 0; ForwardBE = 0; ALUSrcE = 0; ALUControlE = 3'd1; RD2E = RD1E;
    end
  endtask

  initial begin
    model_clear();
    // Reset held with every E input nonzero
    rst = 0;
    RegWriteE = 1; MemWriteE = 1; JumpE = 1; BranchE = 1; ALUSrcE = 1;
    ResultSrcE = 2'd2; ForwardAE = 2'd1; ForwardBE = 2'd1; ALUControlE = 3'd3;
    Funct3E = 3'd1; RD1E = 32'h11; RD2E = 32'h22; PCE = 32'h40; ImmExtE = 32'h8;
    PCPlus4E = 32'h44; RDE = 5'd7; ResultW = 32'h99;
    repeat (3) @(posedge clk);
    #1;
    chk_m("reset");
    chk("reset.PCSrcE", {31'd0, PCSrcE}, 32'd0);
    rst = 1;
    step("post_reset");
    chk("post_reset.RDM", {27'd0, RDM}, 32'd7);

    // add with immediate
    zero_ctrl();
    RD1E = 5; ImmExtE = 7; ALUSrcE = 1; RDE = 3; RegWriteE = 1; PCE = 0; PCPlus4E = 4;
    step("add_imm");
    chk("add_imm.value", ALUResultM, 32'd12);

    // MEM forwarding on A, back-to-back sub
    zero_ctrl();
    RD1E = 32'hF; RD2E = 5; ALUControlE = 3'd1; RegWriteE = 1;
    step("sub1");
    chk("sub1.value", ALUResultM, 32'hA);
    ForwardAE = 2'd2; RD1E = 32'hFF; RD2E = 3;
    step("fwd_mem");
    chk("fwd_mem.value", ALUResultM, 32'd7);

    // Reserved forward select behaves like register path
    ForwardAE = 2'd3; RD1E = 32'h50; RD2E = 32'h10;
    step("fwd_rsvd");
    chk("fwd_rsvd.value", ALUResultM, 32'h40);

    // WB forwarding on B for a store
    zero_ctrl();
    ForwardBE = 2'd1; ResultW = 32'h1234; MemWriteE = 1; RD2E = 32'hDEAD;
    step("fwd_wb");
    chk("fwd_wb.value", WriteDataM, 32'h1234);

    // beq taken / not taken
    zero_ctrl();
    RD1E = 9; RD2E = 9; ALUControlE = 3'd1; BranchE = 1; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF0;
    #2;
    chk("beq_t.PCSrcE", {31'd0, PCSrcE}, 32'd1);
    chk("beq_t.PCTargetE", PCTargetE, 32'hF0);
    step("beq_t");
    RD2E = 8;
    #2;
    chk("beq_nt.PCSrcE", {31'd0, PCSrcE}, 32'd0);
    step("beq_nt");

    // Bubble, then jal, then jump together with a branch
    zero_ctrl();
    RD1E = 32'h3; RD2E = 32'h3;
    step("bubble");
    chk("bubble.RegWriteM", {31'd0, RegWriteM}, 32'd0);
    JumpE = 1; PCPlus4E = 32'h24; RegWriteE = 1; ResultSrcE = 2'd2;
    #2;
    chk("jal.PCSrcE", {31'd0, PCSrcE}, 32'd1);
    step("jal");
    chk("jal.PCPlus4M", PCPlus4M, 32'h24);
    BranchE = 1; RD2E = 32'h1; ALUControlE = 3'd1;
    step("jmp_br");

    // Reset asserted mid-stream
    randomize_inputs();
    JumpE = 1;
    step("pre_rst");
    rst = 0;
    #1;
    model_clear();
    chk_m("mid_rst");
    chk("mid_rst.PCSrcE", {31'd0, PCSrcE}, 32'd0);
    @(posedge clk); #1;
    chk_m("mid_rst_hold");
    rst = 1;
    randomize_inputs();
    step("mid_rst_rel");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline.
- Consumes the ID/EX register outputs of the decode stage and applies forwarding on both operands.
- Runs the ALU, resolves branches and jumps, and drives PCSrcE/PCTargetE back to fetch.
- Registers its results into the EX/MEM pipeline register for the memory stage.

Parameters:
- XLEN, 32, datapath width.
- REGADDR_W, 5, register-index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteE  in  1  register-file write enable for this instruction.
- ResultSrcE  in  2  writeback select (00 ALU, 01 memory, 10 PC+4).
- MemWriteE  in  1  store enable.
- JumpE  in  1  unconditional jump (jal).
- BranchE  in  1  conditional branch.
- ALUControlE  in  3  ALU op code.
- ALUSrcE  in  1  operand B select: 0 register, 1 immediate.
- RD1E, RD2E  in  XLEN  register-file operands.
- PCE  in  XLEN  instruction PC.
- ImmExtE  in  XLEN  sign-extended immediate.
- PCPlus4E  in  XLEN  PC+4.
- RDE  in  REGADDR_W  destination register index.
- ResultW  in  XLEN  writeback-stage result, used for forwarding.
- ForwardAE, ForwardBE  in  2  forwarding selects from the hazard unit.
- PCSrcE  out  1  redirect fetch (combinational).
- PCTargetE  out  XLEN  branch/jump target (combinational).
- RegWriteM, MemWriteM  out  1  registered control signals.
- ResultSrcM  out  2  registered writeback select.
- RDM  out  REGADDR_W  registered destination index.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered data.

Behaviour:
- Reset (rst=0, asynchronous):
  - All EX/MEM registers clear to 0.
  - All M outputs are forced to 0 combinationally while rst=0.
  - PCSrcE is forced to 0 while rst=0.
- Forwarding, operand A (SrcAE), selected by ForwardAE:
  - 00 → RD1E
  - 01 → ResultW
  - 10 → ALUResultM, the internal EX/MEM register
  - 11 → reserved, treated as 00
- Forwarding, operand B: the same mapping using ForwardBE and RD2E produces WriteDataE.
- SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU operations, all XLEN-wide, wrap-around with no overflow trap:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt (signed compare, result 0 or 1)
  - 110 sll, shift amount SrcBE[4:0]
  - 111 srl, shift amount SrcBE[4:0]
- ZeroE = (ALUResultE == 0).
- PCTargetE = PCE + ImmExtE, modulo 2^XLEN.
- PCSrcE = JumpE | (BranchE & ZeroE); beq only unless the optional feature is enabled.
- Latency: exactly 1 cycle, E inputs → M outputs. There is no stall input; the register captures every cycle.
- A bubble arrives as control signals at 0 (from the decode-stage flush). It must propagate RegWriteM=0 and MemWriteM=0, and PCSrcE must stay 0.
- Simultaneous conditions:
  - JumpE=1 with BranchE=1: PCSrcE=1.
  - ForwardAE=10 in the same cycle ALUResultM updates: the pre-edge value is used.
- Reset asserted mid-stream: registers clear immediately. After rst releases, the first edge captures the current E inputs.

Optional Feature:
- Macro: EXEC_FULL_BRANCH_EN.
- When defined:
  - Adds input Funct3E [2:0].
  - Branch condition is decoded from Funct3E: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - Comparisons use SrcAE and WriteDataE independently of the ALU op.
  - Funct3E 010/011 → branch never taken.
- When undefined:
  - The port is absent.
  - Branch taken iff ZeroE (beq semantics).

Decomposition:
- Shared package/header riscv_pkg holds:
  - ALU op codes (ALU_ADD…ALU_SRL)
  - forward-select codes (FWD_REG, FWD_WB, FWD_MEM)
  - ResultSrc codes (RES_ALU, RES_MEM, RES_PC4)
  - branch funct3 codes
- One sub-module, alu: combinational, inputs SrcA, SrcB, ALUControl; outputs Result, Zero.
- Forwarding muxes, branch logic and the EX/MEM register stay in execute_cycle.

Test Plan:
- Reset: hold rst=0 with all E inputs nonzero, toggle clk → every M output and PCSrcE read 0; release rst → next edge captures the inputs.
- Add with immediate: RD1E=5, ImmExtE=7, ALUSrcE=1, ALUControlE=000, RDE=3, RegWriteE=1 → after 1 edge ALUResultM=12, RDM=3, RegWriteM=1.
- MEM forwarding: back-to-back sub (ALUResultM=0xA) then ForwardAE=10, RD1E=0xFF, RD2E=3, sub → ALUResultM=7.
- WB forwarding on B: ForwardBE=01, ResultW=0x1234, MemWriteE=1 → WriteDataM=0x1234, MemWriteM=1.
- beq taken: RD1E=RD2E=9, sub, BranchE=1, PCE=0x100, ImmExtE=0xFFFFFFF0 → PCSrcE=1, PCTargetE=0xF0; with RD2E=8 → PCSrcE=0.
- Bubble/jal: all control 0 → RegWriteM=MemWriteM=0. JumpE=1, PCPlus4E=0x24 → PCSrcE=1, PCPlus4M=0x24 next cycle.
